// File: rtl/armleocpu_cache_arbiter_if.sv
// One cache command/response port: a requester drives cmd/address/store data,
// the responder returns response and load data.
interface armleocpu_cache_arbiter_if;
    logic [3:0]  cmd;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [3:0]  response;
    logic [31:0] load_data;

    modport master (
        output cmd, address, store_data,
        input  response, load_data
    );

    modport slave (
        input  cmd, address, store_data,
        output response, load_data
    );
endinterface

// File: rtl/armleocpu_cache_arbiter.sv
// Round-robin arbiter sharing one cache port between fetch (f) and data (d),
// with a D-side lock that keeps the grant across atomic sequences.
module armleocpu_cache_arbiter #(
    parameter bit FIRST_PRIORITY = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    armleocpu_cache_arbiter_if.slave   f,
    armleocpu_cache_arbiter_if.slave   d,
    input  logic                       d_lock,
    armleocpu_cache_arbiter_if.master  c,
    input  logic                       c_reset_done
);
    localparam logic [3:0] CMD_NONE          = 4'd0;
    localparam logic [3:0] RESP_IDLE         = 4'd0;
    localparam logic [3:0] RESP_WAIT         = 4'd1;
    localparam logic [3:0] RESP_DONE         = 4'd2;
    localparam logic [3:0] RESP_ACCESSFAULT  = 4'd3;
    localparam logic [3:0] RESP_MISSALIGNED  = 4'd4;
    localparam logic [3:0] RESP_PAGEFAULT    = 4'd5;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
    typedef enum logic {PORT_F = 1'b0, PORT_D = 1'b1} port_t;

    state_t state, state_nxt;
    port_t  owner, owner_nxt;
    port_t  last_grant, last_grant_nxt;
    logic   locked, locked_nxt;

    logic   active;
    logic   f_pend, d_pend;
    logic   completing, protocol_idle, can_arb;
    logic   grant;
    port_t  winner;
    port_t  sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= PORT_F;
            last_grant <= FIRST_PRIORITY ? PORT_F : PORT_D;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            locked     <= locked_nxt;
        end
    end

    assign active        = c_reset_done && !rst;
    assign f_pend        = (f.cmd != CMD_NONE);
    assign d_pend        = (d.cmd != CMD_NONE);
    assign completing    = (state == ST_BUSY) && (c.response inside
                           {RESP_DONE, RESP_ACCESSFAULT, RESP_MISSALIGNED, RESP_PAGEFAULT});
    // IDLE while busy is a protocol error: drop ownership without a new grant
    assign protocol_idle = (state == ST_BUSY) && (c.response == RESP_IDLE);
    assign can_arb       = active && ((state == ST_IDLE) || completing);

    always_comb begin
        grant  = 1'b0;
        winner = PORT_F;
        if (can_arb) begin
            if (locked) begin
                grant  = d_pend;
                winner = PORT_D;
            end else if (f_pend && d_pend) begin
                grant  = 1'b1;
                winner = (last_grant == PORT_F) ? PORT_D : PORT_F;
            end else if (f_pend) begin
                grant  = 1'b1;
                winner = PORT_F;
            end else if (d_pend) begin
                grant  = 1'b1;
                winner = PORT_D;
            end
        end
    end

    always_comb begin
        sel = PORT_F;
        if (grant)
            sel = winner;
        else if (active && (state == ST_BUSY))
            sel = owner;

        c.address    = (sel == PORT_D) ? d.address    : f.address;
        c.store_data = (sel == PORT_D) ? d.store_data : f.store_data;
        c.cmd        = CMD_NONE;
        if (grant || (active && (state == ST_BUSY) && !completing && !protocol_idle))
            c.cmd = (sel == PORT_D) ? d.cmd : f.cmd;
    end

    always_comb begin
        f.response = RESP_IDLE;
        d.response = RESP_IDLE;
        if (active) begin
            if ((state == ST_BUSY) && (owner == PORT_F))
                f.response = c.response;
            else if (f_pend)
                f.response = RESP_WAIT;

            if ((state == ST_BUSY) && (owner == PORT_D))
                d.response = c.response;
            else if (d_pend)
                d.response = RESP_WAIT;
        end
    end

    assign f.load_data = c.load_data;
    assign d.load_data = c.load_data;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        locked_nxt     = locked;
        if (active) begin
            if (grant) begin
                state_nxt      = ST_BUSY;
                owner_nxt      = winner;
                last_grant_nxt = winner;
                locked_nxt     = (winner == PORT_D) && d_lock;
            end else if (can_arb || protocol_idle) begin
                state_nxt = ST_IDLE;
            end
        end
    end
endmodule
